spm_1p_mem_initiator: RTL and testbench



---
 rtl/spm_1p_mem_initiator.sv | 102 ++++++++++
 tb/tb_spm_1p_mem_initiator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_1p_mem_initiator.sv
// Request-side initiator for a single-port, latency-1 scratchpad memory.
// Read returns are captured into a response FIFO; a credit counter reserves a slot per issued read.
module spm_1p_mem_initiator #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned RspDepth  = 3,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [BeWidth-1:0]   mem_be_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic [CntWidth-1:0]  outstanding_o
);

    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntWidth-1:0] Depth   = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(RspDepth - 1);

    logic [CntWidth-1:0]  cnt_q;
    logic                 rd_pend_q;
    logic [DataWidth-1:0] fifo_q [RspDepth];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  fifo_cnt_q;
    logic                 accept;
    logic                 rd_accept;
    logic                 push;
    logic                 pop;

    // Writes bypass the credit check: they never occupy a response slot.
    assign req_ready_o = req_we_i | (cnt_q < Depth);
    assign accept      = req_valid_i & req_ready_o;
    assign rd_accept   = accept & ~req_we_i;

    assign mem_req_o   = accept;
    assign mem_we_o    = req_we_i;
    assign mem_addr_o  = req_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    assign push          = rd_pend_q;
    assign rsp_valid_o   = (fifo_cnt_q != '0);
    assign pop           = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o   = fifo_q[rd_ptr_q];
    assign outstanding_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            rd_pend_q <= rd_accept;

            case ({rd_accept, pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase

            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
        end
    end

    // Storage is data only; validity is tracked by the pointers and count above.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_spm_1p_mem_initiator.sv
// Bench for spm_1p_mem_initiator: latency-1 memory model plus a queue-based response reference.
module tb_spm_1p_mem_initiator;

    localparam int D  = 3;
    localparam int DW = 128;
    localparam int AW = 10;
    localparam int BW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] outstanding;

    spm_1p_mem_initiator dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
        .outstanding_o(outstanding)
    );

    initial forever #5 clk = ~clk;

    int unsigned salt;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        acc;
    logic        pop;
    logic        seen_acc;

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } rsp_t;
    rsp_t          q[$];
    logic [DW-1:0] ref_mem [1024];

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return {a * salt, salt ^ a, ~(a + salt), a * 32'h9E3779B1};
    endfunction

    function automatic logic [DW-1:0] bwrite(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                             input logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (b[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    // Latency-1 single-port memory macro model.
    logic [DW-1:0] mem_arr [1024];
    bit            written [1024];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                mem_arr[mem_addr] <= bwrite(written[mem_addr] ? mem_arr[mem_addr] : init_word(32'(mem_addr)),
                                            mem_wdata, mem_be);
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? mem_arr[mem_addr] : init_word(32'(mem_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic we, input int a,
                           input logic [DW-1:0] d, input logic [BW-1:0] b);
        req_valid = v;
        req_we    = we;
        req_addr  = AW'(a);
        req_wdata = d;
        req_be    = b;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the reference at the edge.
    task automatic cycle();
        logic exp_ready;
        logic exp_valid;
        @(negedge clk);
        exp_ready = req_we | (q.size() < D);
        acc       = req_valid & exp_ready;
        exp_valid = (q.size() != 0) && (q[0].avail <= cyc);
        pop       = exp_valid & rsp_ready;
        seen_acc  = mem_req;
        chk("req_ready", DW'(req_ready), DW'(exp_ready));
        chk("mem_req", DW'(mem_req), DW'(acc));
        chk("rsp_valid", DW'(rsp_valid), DW'(exp_valid));
        chk("outstanding", DW'(outstanding), DW'(q.size()));
        if (exp_valid) chk("rsp_rdata", rsp_rdata, q[0].data);
        if (acc) begin
            chk("mem_we", DW'(mem_we), DW'(req_we));
            chk("mem_addr", DW'(mem_addr), DW'(req_addr));
            if (req_we) begin
                chk("mem_wdata", mem_wdata, req_wdata);
                chk("mem_be", DW'(mem_be), DW'(req_be));
            end
        end
        chk("push_full", DW'(dut.rd_pend_q & (dut.fifo_cnt_q == CW'(D))), '0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (req_we) ref_mem[req_addr] = bwrite(ref_mem[req_addr], req_wdata, req_be);
            else q.push_back('{data: ref_mem[req_addr], avail: cyc + 2});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        set_req(1'b0, 1'b0, 0, '0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int            na;
        int            ta;
        logic [7:0]    wbyte;
        logic [DW-1:0] a5;
        a5   = {16{8'hA5}};
        salt = $urandom;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        rst       = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 0, '0, '0);
        #2;
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_outstanding", DW'(outstanding), '0);
        chk("rst_mem_req", DW'(mem_req), '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Full write then read-back of the same word.
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 5, a5, '1);
        cycle();
        set_req(1'b1, 1'b0, 5, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, 0, '0, '0);
        chk("t1_n1_valid", DW'(rsp_valid), '0);
        chk("t1_n1_outstanding", DW'(outstanding), 1);
        cycle();
        chk("t1_n2_valid", DW'(rsp_valid), 1);
        chk("t1_n2_rdata", rsp_rdata, a5);
        chk("t1_n2_outstanding", DW'(outstanding), 1);
        cycle();
        chk("t1_n3_outstanding", DW'(outstanding), 0);
        idle(2);

        // Back-to-back reads at full rate.
        na = 0;
        for (int a = 0; a < 8; a++) begin
            set_req(1'b1, 1'b0, a, '0, '0);
            cycle();
            if (seen_acc) na++;
        end
        chk("t2_accepted", DW'(na), 8);
        idle(4);

        // Consumer stalled: reads limited by credits, writes still pass.
        rsp_ready = 1'b0;
        na = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b0, 16 + na, '0, '0);
            cycle();
            if (seen_acc) na++;
        end
        chk("t3_accepted", DW'(na), 3);
        chk("t3_outstanding", DW'(outstanding), 3);
        chk("t3_rd_blocked", DW'(req_ready), '0);
        set_req(1'b1, 1'b1, 40, {4{$urandom}}, '1);
        cycle();
        chk("t3_wr_accepted", DW'(seen_acc), 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && na < 5; i++) begin
            set_req(1'b1, 1'b0, 16 + na, '0, '0);
            cycle();
            if (seen_acc) na++;
        end
        chk("t3_all_accepted", DW'(na), 5);
        idle(5);

        // Stream, stall to full, then resume while reads keep arriving.
        ta = 0;
        for (int i = 0; i < 20; i++) begin
            rsp_ready = !(i >= 6 && i < 10);
            set_req(1'b1, 1'b0, 100 + ta, '0, '0);
            cycle();
            if (seen_acc) ta++;
        end
        chk("t4_min_accepted", DW'(ta >= 12), 1);
        rsp_ready = 1'b1;
        idle(5);

        // Reset with two reads in flight.
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, 3, '0, '0);
        cycle();
        set_req(1'b1, 1'b0, 4, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, 0, '0, '0);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", DW'(rsp_valid), '0);
        chk("t5_rst_outstanding", DW'(outstanding), '0);
        q.delete();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b0, 9, '0, '0);
        cycle();
        idle(4);

        // Partial write touches only byte 0.
        wbyte = 8'($urandom);
        set_req(1'b1, 1'b1, 5, {{15{8'h3C}}, wbyte}, 16'h0001);
        cycle();
        set_req(1'b1, 1'b0, 5, '0, '0);
        cycle();
        set_req(1'b0, 1'b0, 0, '0, '0);
        cycle();
        chk("t6_valid", DW'(rsp_valid), 1);
        chk("t6_rdata", rsp_rdata, {{15{8'hA5}}, wbyte});
        idle(3);

        // Random traffic on a small address window.
        for (int i = 0; i < 300; i++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 15)), {4{$urandom}}, 16'($urandom));
            cycle();
        end
        rsp_ready = 1'b1;
        idle(6);
        chk("end_outstanding", DW'(outstanding), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
